// File: rtl/flg_match_offset_gen.sv
// Sparse-flag match scanner: walks the channels where both the activation and
// weight flags are set, lowest first, and emits one registered beat per match
// carrying the offsets into the compressed act/wei streams plus word totals.
// A word with no common channel yields a single non-match beat with totals.
module flg_match_offset_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int MODE       = 0,
  localparam int IDX_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1,
  localparam int CNT_W     = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  I_Flush,
  input  logic                  I_Val,
  output logic                  O_Rdy,
  input  logic [DATA_WIDTH-1:0] I_ActFlag,
  input  logic [DATA_WIDTH-1:0] I_WeiFlag,
  output logic                  O_Val,
  input  logic                  I_Rdy,
  output logic                  O_Match,
  output logic                  O_Last,
  output logic [IDX_W-1:0]      O_Chn,
  output logic [IDX_W-1:0]      O_Offset_Act,
  output logic [IDX_W-1:0]      O_Offset_Wei,
  output logic [CNT_W-1:0]      O_ActTot,
  output logic [CNT_W-1:0]      O_WeiTot,
  output logic                  O_Busy
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} stateT;

  stateT                 stateReg, stateNext;
  logic [DATA_WIDTH-1:0] actReg, actNext;
  logic [DATA_WIDTH-1:0] weiReg, weiNext;
  // Matches still to be emitted after the beat currently on the outputs.
  logic [DATA_WIDTH-1:0] pendReg, pendNext;
  logic                  matchReg, matchNext;
  logic                  lastReg, lastNext;
  logic [IDX_W-1:0]      chnReg, chnNext;
  logic [IDX_W-1:0]      offActReg, offActNext;
  logic [IDX_W-1:0]      offWeiReg, offWeiNext;
  logic [CNT_W-1:0]      actTotReg, actTotNext;
  logic [CNT_W-1:0]      weiTotReg, weiTotNext;

  logic                  rdyInt;
  logic                  accept;
  logic                  handshake;

  // Source of the next beat: a freshly accepted word, or the held word.
  logic [DATA_WIDTH-1:0] srcAct, srcWei, srcPend, remPend;
  logic                  srcFirst, firstEff;
  logic                  beatFound;
  logic [IDX_W-1:0]      beatChn, beatOffAct, beatOffWei;
  logic [DATA_WIDTH-1:0] winMask;
  logic [CNT_W-1:0]      inActTot, inWeiTot;

  // Handshake qualifiers; a new word may enter on the final beat's handshake.
  always_comb begin
    rdyInt    = ~I_Flush & ((stateReg == IDLE) | (lastReg & I_Rdy));
    accept    = I_Val & rdyInt;
    handshake = (stateReg == EMIT) & I_Rdy;
  end

  // Select which word/pending mask feeds the beat calculation.
  always_comb begin
    srcAct   = accept ? I_ActFlag : actReg;
    srcWei   = accept ? I_WeiFlag : weiReg;
    srcPend  = accept ? (I_ActFlag & I_WeiFlag) : pendReg;
    srcFirst = accept;
    firstEff = srcFirst | (MODE != 0);
    remPend  = srcPend & (srcPend - DATA_WIDTH'(1));
  end

  // Locate the lowest pending channel.
  always_comb begin
    beatFound = 1'b0;
    beatChn   = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (srcPend[i]) begin
        beatFound = 1'b1;
        beatChn   = IDX_W'(i);
      end
    end
  end

  // Counting window: below the match, and above the previous match in REL mode.
  // The previous match is the channel still held on the outputs.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : gWin
    assign winMask[gi] = (IDX_W'(gi) < beatChn) && (firstEff || (IDX_W'(gi) > chnReg));
  end

  // Offsets are the set flags inside the window; totals cover the whole input word.
  always_comb begin
    beatOffAct = '0;
    beatOffWei = '0;
    inActTot   = '0;
    inWeiTot   = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (srcAct[i] && winMask[i]) beatOffAct = beatOffAct + IDX_W'(1);
      if (srcWei[i] && winMask[i]) beatOffWei = beatOffWei + IDX_W'(1);
      if (I_ActFlag[i])            inActTot   = inActTot + CNT_W'(1);
      if (I_WeiFlag[i])            inWeiTot   = inWeiTot + CNT_W'(1);
    end
  end

  // Next-state and next-beat selection; flush wins over everything.
  always_comb begin
    stateNext  = stateReg;
    actNext    = actReg;
    weiNext    = weiReg;
    pendNext   = pendReg;
    matchNext  = matchReg;
    lastNext   = lastReg;
    chnNext    = chnReg;
    offActNext = offActReg;
    offWeiNext = offWeiReg;
    actTotNext = actTotReg;
    weiTotNext = weiTotReg;
    if (I_Flush || (handshake && lastReg && !accept)) begin
      stateNext  = IDLE;
      pendNext   = '0;
      matchNext  = 1'b0;
      lastNext   = 1'b0;
      chnNext    = '0;
      offActNext = '0;
      offWeiNext = '0;
      actTotNext = '0;
      weiTotNext = '0;
    end else if (accept || handshake) begin
      stateNext  = EMIT;
      pendNext   = remPend;
      matchNext  = beatFound;
      lastNext   = (remPend == '0);
      chnNext    = beatChn;
      offActNext = beatOffAct;
      offWeiNext = beatOffWei;
      if (accept) begin
        actNext    = I_ActFlag;
        weiNext    = I_WeiFlag;
        actTotNext = inActTot;
        weiTotNext = inWeiTot;
      end
    end
  end

  // State and registered beat outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg  <= IDLE;
      actReg    <= '0;
      weiReg    <= '0;
      pendReg   <= '0;
      matchReg  <= 1'b0;
      lastReg   <= 1'b0;
      chnReg    <= '0;
      offActReg <= '0;
      offWeiReg <= '0;
      actTotReg <= '0;
      weiTotReg <= '0;
    end else begin
      stateReg  <= stateNext;
      actReg    <= actNext;
      weiReg    <= weiNext;
      pendReg   <= pendNext;
      matchReg  <= matchNext;
      lastReg   <= lastNext;
      chnReg    <= chnNext;
      offActReg <= offActNext;
      offWeiReg <= offWeiNext;
      actTotReg <= actTotNext;
      weiTotReg <= weiTotNext;
    end
  end

  assign O_Rdy        = rdyInt;
  assign O_Val        = (stateReg == EMIT);
  assign O_Busy       = (stateReg == EMIT);
  assign O_Match      = matchReg;
  assign O_Last       = lastReg;
  assign O_Chn        = chnReg;
  assign O_Offset_Act = offActReg;
  assign O_Offset_Wei = offWeiReg;
  assign O_ActTot     = actTotReg;
  assign O_WeiTot     = weiTotReg;

endmodule

// File: tb/tb_flg_match_offset_gen.sv
// Bench for flg_match_offset_gen: an 8-channel REL instance and a 32-channel
// ABS instance, each with a scoreboard of expected beats built from the flags.
module tb_flg_match_offset_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       flush8, val8, rdy8;
  logic [7:0] act8, wei8;
  logic       oRdy8, oVal8, oMatch8, oLast8, oBusy8;
  logic [2:0] oChn8, oOffA8, oOffW8;
  logic [3:0] oActTot8, oWeiTot8;

  logic        flush32, val32, rdy32;
  logic [31:0] act32, wei32;
  logic        oRdy32, oVal32, oMatch32, oLast32, oBusy32;
  logic [4:0]  oChn32, oOffA32, oOffW32;
  logic [5:0]  oActTot32, oWeiTot32;

  flg_match_offset_gen #(.DATA_WIDTH(8), .MODE(0)) u8 (
    .clk(clk), .rst(rst), .I_Flush(flush8), .I_Val(val8), .O_Rdy(oRdy8),
    .I_ActFlag(act8), .I_WeiFlag(wei8), .O_Val(oVal8), .I_Rdy(rdy8),
    .O_Match(oMatch8), .O_Last(oLast8), .O_Chn(oChn8), .O_Offset_Act(oOffA8),
    .O_Offset_Wei(oOffW8), .O_ActTot(oActTot8), .O_WeiTot(oWeiTot8), .O_Busy(oBusy8)
  );

  flg_match_offset_gen #(.DATA_WIDTH(32), .MODE(1)) u32 (
    .clk(clk), .rst(rst), .I_Flush(flush32), .I_Val(val32), .O_Rdy(oRdy32),
    .I_ActFlag(act32), .I_WeiFlag(wei32), .O_Val(oVal32), .I_Rdy(rdy32),
    .O_Match(oMatch32), .O_Last(oLast32), .O_Chn(oChn32), .O_Offset_Act(oOffA32),
    .O_Offset_Wei(oOffW32), .O_ActTot(oActTot32), .O_WeiTot(oWeiTot32), .O_Busy(oBusy32)
  );

  typedef struct {
    logic [31:0] match, last, chn, offAct, offWei, actTot, weiTot;
  } beatT;

  beatT q8[$];
  beatT q32[$];
  beatT e8, e32;
  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Set flags in v[lo..hi] inclusive; empty range gives 0.
  function automatic int popRange(input logic [31:0] v, input int lo, input int hi);
    int c = 0;
    for (int j = lo; j <= hi; j++) if (v[j]) c++;
    return c;
  endfunction

  // Expected beats of one word. inst 0: 8 ch REL, inst 1: 32 ch ABS.
  task automatic pushWord(input int inst, input logic [31:0] a, input logic [31:0] w);
    int dw, prev;
    bit absMode, any;
    logic [31:0] p;
    beatT b;
    dw = (inst == 0) ? 8 : 32;
    absMode = (inst == 1);
    p = a & w;
    prev = -1;
    any = 1'b0;
    b.actTot = 32'(popRange(a, 0, dw - 1));
    b.weiTot = 32'(popRange(w, 0, dw - 1));
    for (int ch = 0; ch < dw; ch++) begin
      if (p[ch]) begin
        any = 1'b1;
        b.match  = 1;
        b.chn    = 32'(ch);
        b.offAct = 32'(absMode ? popRange(a, 0, ch - 1) : popRange(a, prev + 1, ch - 1));
        b.offWei = 32'(absMode ? popRange(w, 0, ch - 1) : popRange(w, prev + 1, ch - 1));
        b.last   = (((p >> ch) >> 1) == 32'd0) ? 32'd1 : 32'd0;
        if (inst == 0) q8.push_back(b); else q32.push_back(b);
        prev = ch;
      end
    end
    if (!any) begin
      b.match = 0; b.last = 1; b.chn = 0; b.offAct = 0; b.offWei = 0;
      if (inst == 0) q8.push_back(b); else q32.push_back(b);
    end
  endtask

  // Scoreboard for the 8-channel instance; held beats are compared every cycle.
  always @(negedge clk) begin
    if (!rst && oVal8 === 1'b1) begin
      if (q8.size() == 0) check("u8 stray beat", 32'(oVal8), 32'd0);
      else begin
        e8 = q8[0];
        check("u8 match", 32'(oMatch8), e8.match);
        check("u8 last", 32'(oLast8), e8.last);
        check("u8 chn", 32'(oChn8), e8.chn);
        check("u8 offAct", 32'(oOffA8), e8.offAct);
        check("u8 offWei", 32'(oOffW8), e8.offWei);
        if (e8.last == 32'd1) begin
          check("u8 actTot", 32'(oActTot8), e8.actTot);
          check("u8 weiTot", 32'(oWeiTot8), e8.weiTot);
        end
        if (rdy8) q8.delete(0);
      end
    end
  end

  // Scoreboard for the 32-channel instance.
  always @(negedge clk) begin
    if (!rst && oVal32 === 1'b1) begin
      if (q32.size() == 0) check("u32 stray beat", 32'(oVal32), 32'd0);
      else begin
        e32 = q32[0];
        check("u32 match", 32'(oMatch32), e32.match);
        check("u32 last", 32'(oLast32), e32.last);
        check("u32 chn", 32'(oChn32), e32.chn);
        check("u32 offAct", 32'(oOffA32), e32.offAct);
        check("u32 offWei", 32'(oOffW32), e32.offWei);
        if (e32.last == 32'd1) begin
          check("u32 actTot", 32'(oActTot32), e32.actTot);
          check("u32 weiTot", 32'(oWeiTot32), e32.weiTot);
        end
        if (rdy32) q32.delete(0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setRdy(input int inst, input logic r);
    if (inst == 0) rdy8 = r; else rdy32 = r;
  endtask

  task automatic drive(input int inst, input logic v, input logic [31:0] a, input logic [31:0] w);
    if (inst == 0) begin val8 = v; act8 = a[7:0]; wei8 = w[7:0]; end
    else begin val32 = v; act32 = a; wei32 = w; end
  endtask

  function automatic logic busyOf(input int inst);
    return (inst == 0) ? oBusy8 : oBusy32;
  endfunction

  function automatic int qSize(input int inst);
    return (inst == 0) ? q8.size() : q32.size();
  endfunction

  // Drain the word in flight; rdyMode 0: always ready, 1: toggle 1,0,..., 2: random.
  task automatic finishWord(input int inst, input int rdyMode, input string tag);
    int cyc = 0;
    while ((busyOf(inst) || qSize(inst) != 0) && cyc < 200) begin
      case (rdyMode)
        0:       setRdy(inst, 1'b1);
        1:       setRdy(inst, (cyc % 2) == 0);
        default: setRdy(inst, 1'($urandom_range(0, 1)));
      endcase
      step();
      cyc++;
    end
    setRdy(inst, 1'b1);
    check({tag, " idle"}, 32'(busyOf(inst)), 32'd0);
    check({tag, " drained"}, 32'(qSize(inst)), 32'd0);
  endtask

  task automatic runWord(input int inst, input logic [31:0] a, input logic [31:0] w,
                         input int rdyMode, input string tag);
    pushWord(inst, (inst == 0) ? (a & 32'hFF) : a, (inst == 0) ? (w & 32'hFF) : w);
    drive(inst, 1'b1, a, w);
    setRdy(inst, 1'b1);
    step();
    drive(inst, 1'b0, a, w);
    finishWord(inst, rdyMode, tag);
  endtask

  initial begin
    int cyc, total;
    logic [31:0] ra, rw;
    rst = 1'b1;
    flush8 = 0; val8 = 0; rdy8 = 1; act8 = '0; wei8 = '0;
    flush32 = 0; val32 = 0; rdy32 = 1; act32 = '0; wei32 = '0;
    step(); step();
    check("rst u8 rdy", 32'(oRdy8), 32'd1);
    check("rst u8 val", 32'(oVal8), 32'd0);
    check("rst u8 busy", 32'(oBusy8), 32'd0);
    check("rst u8 chn/last", {oChn8, oLast8, oActTot8}, 32'd0);
    check("rst u32 rdy", 32'(oRdy32), 32'd1);
    check("rst u32 val", 32'(oVal32), 32'd0);
    rst = 1'b0;
    step();

    // REL example with explicit first-beat latency check.
    pushWord(0, 32'hB6, 32'h25);
    drive(0, 1'b1, 32'hB6, 32'h25);
    step();
    drive(0, 1'b0, 32'hB6, 32'h25);
    check("rel b1 val", 32'(oVal8), 32'd1);
    check("rel b1 chn", 32'(oChn8), 32'd2);
    check("rel b1 offs", {oOffA8, oOffW8, oLast8}, {25'd0, 3'd1, 3'd1, 1'b0});
    finishWord(0, 0, "rel B6/25");

    // ABS example on the 32-channel instance (same flags).
    runWord(1, 32'hB6, 32'h25, 0, "abs B6/25");

    // Empty word: single non-match beat, ready during its handshake.
    pushWord(0, 32'hF0, 32'h0F);
    drive(0, 1'b1, 32'hF0, 32'h0F);
    step();
    drive(0, 1'b0, 32'hF0, 32'h0F);
    check("empty last", 32'(oLast8), 32'd1);
    check("empty match", 32'(oMatch8), 32'd0);
    check("empty rdy on hs", 32'(oRdy8), 32'd1);
    finishWord(0, 0, "empty");

    // All-ones with a stalling consumer.
    runWord(0, 32'hFF, 32'hFF, 1, "ones toggle");

    // Flush after the first beat with I_Val held high.
    pushWord(0, 32'hFF, 32'hFF);
    drive(0, 1'b1, 32'hFF, 32'hFF);
    step();
    drive(0, 1'b1, 32'h81, 32'h01);
    step();
    flush8 = 1'b1;
    rdy8 = 1'b0;
    #1;
    check("flush rdy low", 32'(oRdy8), 32'd0);
    step();
    q8.delete();
    check("flush val", 32'(oVal8), 32'd0);
    step();
    check("flush no accept", 32'(oBusy8), 32'd0);
    flush8 = 1'b0;
    rdy8 = 1'b1;
    pushWord(0, 32'h81, 32'h01);
    step();
    drive(0, 1'b0, 32'h81, 32'h01);
    check("post-flush accept", 32'(oVal8), 32'd1);
    finishWord(0, 0, "post-flush");

    // Back-to-back words: O_Val must stay high across the word boundary.
    pushWord(1, 32'hF00F_00FF, 32'h0F0F_F0F1);
    pushWord(1, 32'hFFFF_FFFF, 32'h8000_0001);
    total = q32.size();
    drive(1, 1'b1, 32'hF00F_00FF, 32'h0F0F_F0F1);
    step();
    drive(1, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
    cyc = 0;
    while (oVal32 === 1'b1 && cyc < 200) begin
      if (oRdy32 && val32) begin
        step();
        val32 = 1'b0;
      end else step();
      cyc++;
    end
    check("b2b beat cycles", 32'(cyc), 32'(total));
    finishWord(1, 0, "b2b");

    // Random words against the model.
    for (int n = 0; n < 6; n++) begin
      ra = $urandom;
      rw = (n % 2 == 0) ? $urandom : ($urandom & $urandom);
      $display("[TB] random word %0d A=%08h W=%08h", n, ra, rw);
      runWord(1, ra, rw, 2, "random");
    end

    // Asynchronous reset in the middle of a word.
    pushWord(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drive(1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    drive(1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(); step();
    #2;
    rst = 1'b1;
    #1;
    check("async rst val", 32'(oVal32), 32'd0);
    check("async rst busy", 32'(oBusy32), 32'd0);
    check("async rst rdy", 32'(oRdy32), 32'd1);
    q32.delete();
    step();
    rst = 1'b0;
    step();
    check("post rst idle", 32'(oVal32), 32'd0);
    runWord(1, 32'h0000_8001, 32'h8000_8001, 0, "post rst word");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
